// File: rtl/ws2812_arb_pkg.sv
// Shared types and widths for the WS2812 frame arbiter.
package ws2812_arb_pkg;
    localparam int CFG_NUM_W  = 6;
    localparam int CFG_DATA_W = 24;
    localparam int PCNT_W     = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        GAP
    } arb_state_t;
endpackage

// File: rtl/ws2812_arb_pick.sv
// Combinational winner pick: eligible (+ pointer) -> one-hot winner, zero if none eligible.
// WS_ARB_ROUND_ROBIN_EN selects circular search from the pointer; otherwise lowest index wins.
module ws2812_arb_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         eligible,
`ifdef WS_ARB_ROUND_ROBIN_EN
    input  logic [$clog2(N_REQ)-1:0] ptr,
`endif
    output logic [N_REQ-1:0]         winner
);
`ifdef WS_ARB_ROUND_ROBIN_EN
    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
`else
    // Isolate the lowest set bit.
    assign winner = eligible & (~eligible + N_REQ'(1));
`endif
endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Frame-atomic arbiter sharing one ws2812_ctrl serializer between N_REQ frame generators.
// Build option WS_ARB_ROUND_ROBIN_EN: round-robin pick instead of fixed lowest-index priority.
module ws2812_frame_arbiter
    import ws2812_arb_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int LED_NUM = 64,
    parameter int GAP_CYC = 15000
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [N_REQ-1:0]              req_start,
    input  logic [N_REQ-1:0]              req_en,
    input  logic [CFG_NUM_W*N_REQ-1:0]    req_num,
    input  logic [CFG_DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]              req_cfg_start,
    output logic                          ctrl_start,
    output logic [CFG_NUM_W-1:0]          ctrl_num,
    output logic [CFG_DATA_W-1:0]         ctrl_data,
    input  logic                          ctrl_cfg_start,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic                          frame_done
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    arb_state_t         state, state_nxt;
    logic [N_REQ-1:0]   start_q;
    logic [N_REQ-1:0]   pending;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   winner;
    logic [N_REQ-1:0]   take;
    logic [PCNT_W-1:0]  pulse_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pulse_last;
    logic               gap_last;

    assign eligible   = pending & req_en;
    assign take       = (state == IDLE) ? winner : '0;
    assign pulse_last = ctrl_cfg_start && (pulse_cnt == PCNT_W'(LED_NUM - 1));
    assign gap_last   = (gap_cnt == GAP_W'(GAP_CYC - 1));

`ifdef WS_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner_idx;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) owner_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr <= '0;
        end else if (frame_done) begin
            ptr <= (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
        end
    end

    ws2812_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner)
    );
`else
    ws2812_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .eligible (eligible),
        .winner   (winner)
    );
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|eligible) state_nxt = START;
            START:   state_nxt = STREAM;
            STREAM:  if (pulse_last) state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ctrl_start    = (state == START);
        busy          = (state != IDLE);
        frame_done    = (state == GAP) && gap_last;
        req_cfg_start = (state == STREAM && ctrl_cfg_start) ? grant : '0;
        ctrl_num      = '0;
        ctrl_data     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                ctrl_num  = ctrl_num  | req_num[CFG_NUM_W*i +: CFG_NUM_W];
                ctrl_data = ctrl_data | req_data[CFG_DATA_W*i +: CFG_DATA_W];
            end
        end
    end

    // A new edge in the same cycle as the grant re-arms the pending bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            start_q <= '0;
            pending <= '0;
        end else begin
            start_q <= req_start;
            pending <= (pending & ~take) | (req_start & ~start_q);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant <= '0;
        end else if (state == IDLE && |eligible) begin
            grant <= winner;
        end else if (frame_done) begin
            grant <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pulse_cnt <= '0;
        end else if (state == START) begin
            pulse_cnt <= '0;
        end else if (state == STREAM && ctrl_cfg_start && pulse_cnt != '1) begin
            pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_cnt <= '0;
        end else if (state != GAP) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_W'(GAP_CYC)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Directed bench for ws2812_frame_arbiter (N_REQ=3, LED_NUM=4, GAP_CYC=10) with an expected-grant queue.
// Expected grant order follows WS_ARB_ROUND_ROBIN_EN when defined.
module tb_ws2812_frame_arbiter;
    localparam int N_REQ   = 3;
    localparam int LED_NUM = 4;
    localparam int GAP_CYC = 10;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [N_REQ-1:0]     req_start;
    logic [N_REQ-1:0]     req_en;
    logic [6*N_REQ-1:0]   req_num;
    logic [24*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     req_cfg_start;
    logic                 ctrl_start;
    logic [5:0]           ctrl_num;
    logic [23:0]          ctrl_data;
    logic                 ctrl_cfg_start;
    logic [N_REQ-1:0]     grant;
    logic                 busy;
    logic                 frame_done;

    logic [5:0]  num_tab  [N_REQ] = '{6'd9, 6'd5, 6'd33};
    logic [23:0] data_tab [N_REQ] = '{24'h00AA55, 24'hFF0000, 24'h123456};
    logic [2:0]  exp_q [$];
    int tests = 0;
    int fails = 0;

    assign req_num  = {num_tab[2], num_tab[1], num_tab[0]};
    assign req_data = {data_tab[2], data_tab[1], data_tab[0]};

    always #5 sys_clk = ~sys_clk;

    ws2812_frame_arbiter #(.N_REQ(N_REQ), .LED_NUM(LED_NUM), .GAP_CYC(GAP_CYC)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .req_start      (req_start),
        .req_en         (req_en),
        .req_num        (req_num),
        .req_data       (req_data),
        .req_cfg_start  (req_cfg_start),
        .ctrl_start     (ctrl_start),
        .ctrl_num       (ctrl_num),
        .ctrl_data      (ctrl_data),
        .ctrl_cfg_start (ctrl_cfg_start),
        .grant          (grant),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n      = 1'b0;
        req_start      = '0;
        ctrl_cfg_start = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
    endtask

    task automatic pulse_req(input logic [2:0] mask);
        req_start = mask;
        step();
        req_start = '0;
    endtask

    // Waits for the next frame, checks owner/mux/routing/gap against the queue head.
    task automatic run_frame(input logic [2:0] rereq, input bit gap_noise);
        logic [2:0] g;
        int n;
        int oi;
        n = 0;
        while (ctrl_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("ctrl_start_seen", ctrl_start, 1);
        if (ctrl_start !== 1'b1) return;
        g  = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        oi = (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : 2;
        check("grant", grant, g);
        check("busy_start", busy, 1);
        check("ctrl_num", ctrl_num, num_tab[oi]);
        check("ctrl_data", ctrl_data, data_tab[oi]);
        step();
        for (int p = 0; p < LED_NUM; p++) begin
            ctrl_cfg_start = 1'b1;
            if (p == 0) req_start = rereq;
            #1;
            check("route", req_cfg_start, g);
            step();
            ctrl_cfg_start = 1'b0;
            req_start      = '0;
            if (p != LED_NUM - 1) step();
        end
        n = 1;
        while (frame_done !== 1'b1 && n < GAP_CYC + 20) begin
            step();
            n++;
            if (gap_noise && (n == 3 || n == 5)) begin
                ctrl_cfg_start = 1'b1;
                #1;
                check("gap_route", req_cfg_start, 0);
            end else begin
                ctrl_cfg_start = 1'b0;
            end
        end
        ctrl_cfg_start = 1'b0;
        check("gap_len", n, GAP_CYC);
        step();
        check("grant_idle", grant, 0);
        check("busy_idle", busy, 0);
        check("frame_done_once", frame_done, 0);
        check("ctrl_num_idle", ctrl_num, 0);
        check("ctrl_data_idle", ctrl_data, 0);
    endtask

    initial begin
        int lat;
        bit saw;
        req_en = 3'b111;
        sys_rst_n = 1'b0;
        req_start = '0;
        ctrl_cfg_start = 1'b0;
        #12;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl_start", ctrl_start, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ctrl_num", ctrl_num, 0);
        check("rst_ctrl_data", ctrl_data, 0);
        do_reset();

        // Single request from requester 1; the req edge cycle counts as cycle 1.
        step();
        req_start = 3'b010;
        exp_q.push_back(3'b010);
        lat = 1;
        while (ctrl_start !== 1'b1 && lat < 20) begin
            step();
            req_start = '0;
            lat++;
        end
        check("start_latency", lat, 3);
        run_frame(3'b000, 1'b0);

        // All three at once, requester 0 re-requests during its own frame.
        do_reset();
        step();
`ifdef WS_ARB_ROUND_ROBIN_EN
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        exp_q.push_back(3'b100); exp_q.push_back(3'b001);
`else
        exp_q.push_back(3'b001); exp_q.push_back(3'b001);
        exp_q.push_back(3'b010); exp_q.push_back(3'b100);
`endif
        pulse_req(3'b111);
        run_frame(3'b001, 1'b0);
        run_frame(3'b000, 1'b0);
        run_frame(3'b000, 1'b0);
        run_frame(3'b000, 1'b0);

        // Masked pending request is held, then served once enabled.
        req_en = 3'b011;
        pulse_req(3'b100);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy === 1'b1 || grant !== 3'b000) saw = 1'b1;
        end
        check("masked_no_grant", saw, 0);
        req_en = 3'b111;
        exp_q.push_back(3'b100);
        step();
        check("unmask_grant", grant, 3'b100);
        run_frame(3'b000, 1'b0);

        // Stray ctrl_cfg_start pulses inside the gap.
        exp_q.push_back(3'b001);
        pulse_req(3'b001);
        run_frame(3'b000, 1'b1);

        // Asynchronous reset in the middle of a stream.
        pulse_req(3'b010);
        lat = 0;
        while (ctrl_start !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("rst_test_start", ctrl_start, 1);
        step();
        for (int p = 0; p < 2; p++) begin
            ctrl_cfg_start = 1'b1;
            step();
            ctrl_cfg_start = 1'b0;
        end
        pulse_req(3'b100);
        #2;
        ctrl_cfg_start = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_ctrl_start", ctrl_start, 0);
        check("arst_route", req_cfg_start, 0);
        check("arst_ctrl_num", ctrl_num, 0);
        check("arst_ctrl_data", ctrl_data, 0);
        check("arst_frame_done", frame_done, 0);
        ctrl_cfg_start = 1'b0;
        step();
        sys_rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ctrl_start === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        check("post_rst_idle", saw, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
